ps2_move_sched: RTL and testbench
=================================

// Module: ps2_move_sched
// PURPOSE
//  Decodes the PS/2 scan-code byte stream (make, F0 break, E0 extended prefixes) into a held-key
//  mask for four directions. Tracks the most recently pressed direction and issues one paced move
//  request per tick to the game engine over a req/ack handshake. Pulses a pause toggle on P.
//  Sits between the PS/2 receiver (byte + strobe) and the Pacman movement logic.
// PARAMETERS
//  TICK_CYCLES   1250000    clocks per move tick (counter wraps at TICK_CYCLES-1)
//  STALE_CYCLES  50000000   clocks with no code_valid before held mask is force-cleared; 0 = disabled
// PORTS
//  clock         in   1   system clock, all logic on posedge
//  reset         in   1   synchronous, active-high
//  code_valid    in   1   one-cycle strobe: code holds a received scan byte
//  code          in   8   scan byte from PS/2 receiver
//  move_ack      in   1   engine accepted current move request
//  move_req      out  1   move request pending
//  move_dir      out  2   00 up, 01 down, 10 left, 11 right; stable while move_req=1
//  held          out  4   {right,left,down,up} key-held mask
//  pause_pulse   out  1   one-cycle pulse on P (0x4D) make
// BEHAVIOUR
//  Reset: move_req=0, move_dir=00, held=0, pause_pulse=0, last_dir=00, FSM=IDLE, tick and stale counters=0.
//  Reset mid-handshake drops the pending request; no ack is required afterwards.
//  Prefix FSM (advances only on code_valid):
//   IDLE:    E0->EXT; F0->BRK; other->make(code), stay IDLE
//   EXT:     F0->EXT_BRK; E0->EXT; other->make(code), ->IDLE
//   BRK:     E0->EXT_BRK; F0->BRK; other->break(code), ->IDLE
//   EXT_BRK: E0/F0->EXT_BRK; other->break(code), ->IDLE
//  Key map (extended and non-extended treated alike): 75/1D up, 72/1B down, 6B/1C left, 74/23 right.
//  Unmapped bytes, including E1, are consumed and return the FSM to IDLE with no effect.
//  make(dir): set held[dir]; last_dir=dir. Typematic repeats are idempotent.
//  break(dir): clear held[dir]. If dir==last_dir and other bits remain held, last_dir=lowest held index
//   (up>down>left>right). If none remain held, last_dir is unchanged.
//  make(4D) in IDLE/EXT: pause_pulse=1 for exactly one cycle. Break of 4D: no effect.
//  Latency: code_valid at cycle n -> held/last_dir/pause_pulse updated at n+1.
//  Tick counter free-runs 0..TICK_CYCLES-1 and wraps. tick=1 on the cycle the count equals TICK_CYCLES-1.
//  On tick, with held!=0 and move_req=0: next cycle move_req=1 and move_dir=last_dir, latched.
//  Handshake:
//   - move_req holds until move_ack is sampled 1; cleared the following cycle.
//   - move_dir is frozen while move_req=1, even if keys change.
//   - A tick while move_req=1 is dropped, including a tick coincident with ack. Ack wins; no new req that cycle.
//   - move_ack while move_req=0 is ignored.
//  Stale watchdog: counter resets on every code_valid and increments otherwise.
//   At STALE_CYCLES-1: held=0, FSM=IDLE, counter=0. Any pending move_req is kept.
//   Same-cycle code_valid and stale expiry: code_valid wins; counter resets and the byte is processed.
//  Widths: tick and stale counters are 32-bit unsigned and saturate-free (wrap by compare only).
// TESTING  (bench params TICK_CYCLES=8, STALE_CYCLES=100)
//  1. Bytes 1D; wait tick -> held=0001, move_req=1, move_dir=00. Ack -> req=0 next cycle.
//     Next tick -> req again with dir=00.
//  2. E0 6B, then E0 74 -> held=1100, last_dir=11. Then E0 F0 74 -> held=0100, next req move_dir=10.
//  3. Make 75, 72, then break 72 -> held=0001, last_dir=00. Break 75 -> held=0, no further move_req.
//  4. Hold 23, never ack for 3 ticks -> single req held with dir=11. Press 1C mid-wait -> dir stays 11.
//     Ack coincident with tick -> req=0, no new req until the following tick.
//  5. Make 1B, then no bytes for 100 cycles -> held=0 at cycle 100. Bytes 4D -> one-cycle pause_pulse.
//  6. Send E0 F0, assert reset, release, send 1D -> held=0001 (FSM restarted in IDLE, treated as make).

Source files
------------

// File: rtl/ps2_move_sched_if.sv
// Bus between the PS/2 receiver/game engine side and the move scheduler.
interface ps2_move_sched_if;
    logic       code_valid;
    logic [7:0] code;
    logic       move_ack;
    logic       move_req;
    logic [1:0] move_dir;
    logic [3:0] held;
    logic       pause_pulse;

    modport master (
        output code_valid, code, move_ack,
        input  move_req, move_dir, held, pause_pulse
    );

    modport slave (
        input  code_valid, code, move_ack,
        output move_req, move_dir, held, pause_pulse
    );
endinterface

// File: rtl/ps2_move_sched.sv
// PS/2 scan-code decoder for four direction keys plus pause, with a
// tick-paced req/ack move scheduler and a stale-input watchdog.
module ps2_move_sched #(
    parameter int unsigned TICK_CYCLES  = 1250000,
    parameter int unsigned STALE_CYCLES = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    ps2_move_sched_if.slave  bus
);
    localparam int unsigned CNT_W      = 32;
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALE_LAST = CNT_W'(STALE_CYCLES - 1);
    localparam bit               STALE_EN   = (STALE_CYCLES != 0);
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_PAUSE = 8'h4D;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] stale_cnt;
    logic [1:0]       last_dir;
    logic [3:0]       held_q;
    logic             req_q;
    logic [1:0]       dir_q;
    logic             pause_q;

    logic       tick;
    logic       key_hit;
    logic [1:0] key_dir;
    logic [3:0] dir_bit;
    logic [3:0] held_mk;
    logic [3:0] held_bk;
    logic [1:0] last_mk;
    logic [1:0] last_bk;
    logic [1:0] low_dir;
    logic       is_pause;

    assign tick = (tick_cnt == TICK_LAST);

    // Direction key map; extended and plain codes share a slot.
    always_comb begin
        key_hit = 1'b1;
        key_dir = 2'd0;
        case (bus.code)
            8'h75, 8'h1D: key_dir = 2'd0;
            8'h72, 8'h1B: key_dir = 2'd1;
            8'h6B, 8'h1C: key_dir = 2'd2;
            8'h74, 8'h23: key_dir = 2'd3;
            default:      key_hit = 1'b0;
        endcase
    end

    // Candidate held/last_dir values for a make or break of the current byte.
    always_comb begin
        dir_bit  = key_hit ? (4'b0001 << key_dir) : 4'b0000;
        held_mk  = held_q | dir_bit;
        held_bk  = held_q & ~dir_bit;
        last_mk  = key_hit ? key_dir : last_dir;
        is_pause = (bus.code == CODE_PAUSE);
        if (held_bk[0])      low_dir = 2'd0;
        else if (held_bk[1]) low_dir = 2'd1;
        else if (held_bk[2]) low_dir = 2'd2;
        else                 low_dir = 2'd3;
        last_bk = last_dir;
        if (key_hit && (key_dir == last_dir) && (held_bk != 4'b0000)) begin
            last_bk = low_dir;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            stale_cnt <= '0;
            last_dir  <= 2'd0;
            held_q    <= 4'b0000;
            req_q     <= 1'b0;
            dir_q     <= 2'd0;
            pause_q   <= 1'b0;
        end else begin
            pause_q  <= 1'b0;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

            // Ack has priority; ticks during an outstanding request are dropped.
            if (req_q) begin
                if (bus.move_ack) req_q <= 1'b0;
            end else if (tick && (held_q != 4'b0000)) begin
                req_q <= 1'b1;
                dir_q <= last_dir;
            end

            if (bus.code_valid) begin
                stale_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.code == CODE_EXT)      state <= EXT;
                        else if (bus.code == CODE_BRK) state <= BRK;
                        else begin
                            held_q   <= held_mk;
                            last_dir <= last_mk;
                            pause_q  <= is_pause;
                        end
                    end
                    EXT: begin
                        if (bus.code == CODE_BRK)      state <= EXT_BRK;
                        else if (bus.code == CODE_EXT) state <= EXT;
                        else begin
                            held_q   <= held_mk;
                            last_dir <= last_mk;
                            pause_q  <= is_pause;
                            state    <= IDLE;
                        end
                    end
                    BRK: begin
                        if (bus.code == CODE_EXT)      state <= EXT_BRK;
                        else if (bus.code == CODE_BRK) state <= BRK;
                        else begin
                            held_q   <= held_bk;
                            last_dir <= last_bk;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        if ((bus.code != CODE_EXT) && (bus.code != CODE_BRK)) begin
                            held_q   <= held_bk;
                            last_dir <= last_bk;
                            state    <= IDLE;
                        end
                    end
                endcase
            end else if (STALE_EN && (stale_cnt == STALE_LAST)) begin
                held_q    <= 4'b0000;
                state     <= IDLE;
                stale_cnt <= '0;
            end else begin
                stale_cnt <= stale_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.move_req    = req_q;
    assign bus.move_dir    = dir_q;
    assign bus.held        = held_q;
    assign bus.pause_pulse = pause_q;
endmodule

// File: tb/tb_ps2_move_sched.sv
// Randomized and directed bench for ps2_move_sched against a behavioural model.
module tb_ps2_move_sched;
    localparam int TICK  = 8;
    localparam int STALE = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ps2_move_sched_if bus ();

    ps2_move_sched #(.TICK_CYCLES(TICK), .STALE_CYCLES(STALE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: prefix flags, held keys, last direction, request, counters.
    bit       m_ext, m_brk;
    bit [3:0] m_held;
    int       m_last;
    bit       m_req;
    int       m_dir;
    bit       m_pause;
    int       m_n;
    int       m_idle;

    logic [7:0] pool [13] = '{8'h75, 8'h1D, 8'h72, 8'h1B, 8'h6B, 8'h1C,
                              8'h74, 8'h23, 8'hE0, 8'hF0, 8'h4D, 8'hE1, 8'h00};

    function automatic int key_of(input logic [7:0] c);
        case (c)
            8'h75, 8'h1D: return 0;
            8'h72, 8'h1B: return 1;
            8'h6B, 8'h1C: return 2;
            8'h74, 8'h23: return 3;
            default:      return -1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_ext = 0; m_brk = 0; m_held = 0; m_last = 0;
            m_req = 0; m_dir = 0; m_pause = 0; m_n = 0; m_idle = 0;
        end else begin
            bit tick;
            tick = ((m_n % TICK) == TICK - 1);
            m_n++;
            m_pause = 0;
            if (m_req) begin
                if (bus.move_ack) m_req = 0;
            end else if (tick && m_held != 0) begin
                m_req = 1;
                m_dir = m_last;
            end
            if (bus.code_valid) begin
                m_idle = 0;
                if (bus.code == 8'hE0) m_ext = 1;
                else if (bus.code == 8'hF0) m_brk = 1;
                else begin
                    int d;
                    d = key_of(bus.code);
                    if (!m_brk) begin
                        if (d >= 0) begin m_held[d] = 1; m_last = d; end
                        if (bus.code == 8'h4D) m_pause = 1;
                    end else if (d >= 0) begin
                        m_held[d] = 0;
                        if (d == m_last && m_held != 0) begin
                            for (int k = 3; k >= 0; k--) if (m_held[k]) m_last = k;
                        end
                    end
                    m_ext = 0;
                    m_brk = 0;
                end
            end else if (m_idle == STALE - 1) begin
                m_held = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("move_req",    32'(bus.move_req),    32'(m_req));
            chk("move_dir",    32'(bus.move_dir),    32'(m_dir));
            chk("held",        32'(bus.held),        32'(m_held));
            chk("pause_pulse", 32'(bus.pause_pulse), 32'(m_pause));
        end
    end

    task automatic send(input logic [7:0] b);
        bus.code_valid = 1'b1;
        bus.code       = b;
        @(negedge clock);
        bus.code_valid = 1'b0;
    endtask

    task automatic ack_once();
        bus.move_ack = 1'b1;
        @(negedge clock);
        bus.move_ack = 1'b0;
    endtask

    task automatic drain();
        if (bus.move_req === 1'b1) ack_once();
    endtask

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (bus.move_req !== 1'b1 && k < 3 * TICK) begin
            @(negedge clock);
            k++;
        end
        chk(name, 32'(bus.move_req), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        bus.move_ack   = 1'b0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_held", 32'(bus.held), 32'd0);
        chk("rst_req",  32'(bus.move_req), 32'd0);
        chk("rst_dir",  32'(bus.move_dir), 32'd0);
        reset = 1'b0;

        // 1: single key, paced request, ack, repeat request
        send(8'h1D);
        wait_req("s1_req");
        chk("s1_dir", 32'(bus.move_dir), 32'd0);
        chk("s1_held", 32'(bus.held), 32'h1);
        ack_once();
        chk("s1_ack_clr", 32'(bus.move_req), 32'd0);
        wait_req("s1_req2");
        chk("s1_dir2", 32'(bus.move_dir), 32'd0);
        ack_once();

        // 2: extended makes and extended break
        send(8'hF0); send(8'h1D);
        drain();
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h74);
        chk("s2_held_c", 32'(bus.held), 32'hC);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("s2_held_4", 32'(bus.held), 32'h4);
        drain();
        wait_req("s2_req");
        chk("s2_dir", 32'(bus.move_dir), 32'd2);
        ack_once();

        // 3: fallback of last_dir on break, then nothing held
        send(8'hF0); send(8'h6B);
        send(8'h75); send(8'h72);
        send(8'hF0); send(8'h72);
        chk("s3_held_1", 32'(bus.held), 32'h1);
        send(8'hF0); send(8'h75);
        chk("s3_held_0", 32'(bus.held), 32'h0);
        drain();
        seen = 0;
        repeat (3 * TICK) begin
            @(negedge clock);
            if (bus.move_req === 1'b1) seen++;
        end
        chk("s3_no_req", 32'(seen), 32'd0);

        // 4: frozen direction while unacked; ack coincident with tick
        send(8'h23);
        wait_req("s4_req");
        chk("s4_dir", 32'(bus.move_dir), 32'd3);
        send(8'h1C);
        repeat (3 * TICK) @(negedge clock);
        chk("s4_req_hold", 32'(bus.move_req), 32'd1);
        chk("s4_dir_frozen", 32'(bus.move_dir), 32'd3);
        while ((m_n % TICK) != TICK - 1) @(negedge clock);
        ack_once();
        chk("s4_ack_tick", 32'(bus.move_req), 32'd0);
        repeat (TICK - 1) @(negedge clock);
        chk("s4_no_req_yet", 32'(bus.move_req), 32'd0);
        wait_req("s4_req_next");
        chk("s4_dir_next", 32'(bus.move_dir), 32'd2);
        ack_once();

        // 5: stale watchdog and pause pulse
        send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h1C);
        drain();
        send(8'h1B);
        repeat (99) @(negedge clock);
        chk("s5_held_before", 32'(bus.held), 32'h2);
        @(negedge clock);
        chk("s5_held_stale", 32'(bus.held), 32'h0);
        send(8'h4D);
        chk("s5_pause_on", 32'(bus.pause_pulse), 32'd1);
        @(negedge clock);
        chk("s5_pause_off", 32'(bus.pause_pulse), 32'd0);
        drain();

        // 6: reset mid-prefix restarts the decoder
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        send(8'h1D);
        chk("s6_held", 32'(bus.held), 32'h1);
        chk("s6_req", 32'(bus.move_req), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 500) begin
                bus.code_valid = 1'b0;
                repeat (130) begin
                    bus.move_ack = ($urandom_range(0, 3) == 0);
                    @(negedge clock);
                end
            end
            if (i == 3000) reset = 1'b1;
            if (i == 3002) reset = 1'b0;
            if ($urandom_range(0, 99) < 35) begin
                int p;
                p = int'($urandom_range(0, 12));
                bus.code_valid = 1'b1;
                bus.code = (p == 12) ? 8'($urandom_range(0, 255)) : pool[p];
            end else begin
                bus.code_valid = 1'b0;
            end
            bus.move_ack = ($urandom_range(0, 3) == 0);
            @(negedge clock);
        end
        bus.code_valid = 1'b0;
        bus.move_ack   = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
